parking_gate_controller: RTL and testbench

- Front-end stage that sits directly upstream of car_parking_system; owns both the entry gate and the exit gate.
- Debounces raw loop sensors and sequences each gate barrier.
- Emits exactly one single-cycle car_enter pulse per completed entry and one car_leave pulse per completed exit.
- Refuses entry while parking_full is fed back high from the downstream occupancy block.

---
 rtl/parking_pkg.sv | 32 +++
 rtl/gate_lane.sv | 138 +++++++++++++
 rtl/parking_gate_controller.sv | 98 +++++++++
 tb/tb_parking_gate_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared lane state encoding, default timing constants and
//                counter sizing helper for the parking gate controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES  = 4;
    localparam int DEFAULT_GATE_MOVE_CYCLES = 8;
    localparam int DEFAULT_PASS_TIMEOUT     = 64;

    typedef enum logic [2:0] {
        LANE_IDLE    = 3'd0,
        LANE_OPENING = 3'd1,
        LANE_OPEN    = 3'd2,
        LANE_PASSING = 3'd3,
        LANE_CLOSING = 3'd4
    } lane_state_t;

    // Width able to hold (max(a, b) - 1); both counters count down/up to N-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_GATE_MOVE_CYCLES, DEFAULT_PASS_TIMEOUT);

endpackage
`default_nettype wire

// File: rtl/gate_lane.sv
`default_nettype none
// ============================================================================
//  Module      : gate_lane
//  Description : One barrier lane: debounces the arrival and pass loops and
//                sequences the barrier through open / pass / close, emitting
//                a one-cycle done strobe for every completed passage.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_lane
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int GATE_MOVE_CYCLES = DEFAULT_GATE_MOVE_CYCLES,
    parameter int PASS_TIMEOUT     = DEFAULT_PASS_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arrive_raw,
    input  logic        pass_raw,
    input  logic        allow,
    output logic        gate_open,
    output logic        done,
    output logic        arrive_db,
    output lane_state_t state
);

    localparam int CNT_W = cnt_width(GATE_MOVE_CYCLES, PASS_TIMEOUT);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(GATE_MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(PASS_TIMEOUT - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       raw_vec;
    logic [1:0]       db_vec;
    logic             pass_db;
    logic             pass_prev;
    logic [CNT_W-1:0] cnt;

    assign raw_vec   = {pass_raw, arrive_raw};
    assign arrive_db = db_vec[0];
    assign pass_db   = db_vec[1];

    // Bit 0 debounces the arrival loop, bit 1 the pass loop.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_deb
            logic            db_q;
            logic [DB_W-1:0] db_cnt;

            // Adopt the raw value only after DEBOUNCE_CYCLES consecutive mismatching samples.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_q   <= 1'b0;
                    db_cnt <= '0;
                end else if (raw_vec[g] != db_q) begin
                    if (db_cnt == DB_LAST) begin
                        db_q   <= raw_vec[g];
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end

            assign db_vec[g] = db_q;
        end
    endgenerate

    // Barrier sequencer with registered gate command and done strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LANE_IDLE;
            cnt       <= '0;
            gate_open <= 1'b0;
            done      <= 1'b0;
            pass_prev <= 1'b0;
        end else begin
            done      <= 1'b0;
            pass_prev <= pass_db;
            case (state)
                LANE_IDLE: begin
                    // allow is only consulted here; later changes never abort a lane.
                    if (arrive_db && allow) begin
                        state     <= LANE_OPENING;
                        cnt       <= MOVE_LOAD;
                        gate_open <= 1'b1;
                    end
                end
                LANE_OPENING: begin
                    if (cnt == '0) begin
                        state <= LANE_OPEN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LANE_OPEN: begin
                    // Only a fresh rise counts, so a loop already occupied
                    // while the barrier was moving does not register a pass.
                    if (pass_db && !pass_prev) begin
                        state <= LANE_PASSING;
                    end else if (arrive_db) begin
                        cnt <= '0;
                    end else if (cnt == TMO_LAST) begin
                        state     <= LANE_CLOSING;
                        cnt       <= MOVE_LOAD;
                        gate_open <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LANE_PASSING: begin
                    if (!pass_db) begin
                        state     <= LANE_CLOSING;
                        cnt       <= MOVE_LOAD;
                        gate_open <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                LANE_CLOSING: begin
                    if (cnt == '0) begin
                        state <= LANE_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= LANE_IDLE;
                    cnt       <= '0;
                    gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/parking_gate_controller.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_controller
//  Description : Entry/exit gate front end. Two barrier lanes, the FULL lamp,
//                and the car_enter / car_leave pulse generation with
//                same-cycle collision arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int GATE_MOVE_CYCLES = DEFAULT_GATE_MOVE_CYCLES,
    parameter int PASS_TIMEOUT     = DEFAULT_PASS_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_arrive_raw,
    input  logic entry_pass_raw,
    input  logic exit_arrive_raw,
    input  logic exit_pass_raw,
    input  logic parking_full,
    output logic car_enter,
    output logic car_leave,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic entry_denied
);

    logic        entry_done;
    logic        exit_done;
    logic        entry_arrive_db;
    logic        exit_arrive_db;
    lane_state_t entry_state;
    lane_state_t exit_state;
    logic        leave_pending;
    logic        unused_exit;

    gate_lane #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .GATE_MOVE_CYCLES (GATE_MOVE_CYCLES),
        .PASS_TIMEOUT     (PASS_TIMEOUT)
    ) u_entry_lane (
        .clk        (clk),
        .reset      (reset),
        .arrive_raw (entry_arrive_raw),
        .pass_raw   (entry_pass_raw),
        .allow      (!parking_full),
        .gate_open  (entry_gate_open),
        .done       (entry_done),
        .arrive_db  (entry_arrive_db),
        .state      (entry_state)
    );

    gate_lane #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .GATE_MOVE_CYCLES (GATE_MOVE_CYCLES),
        .PASS_TIMEOUT     (PASS_TIMEOUT)
    ) u_exit_lane (
        .clk        (clk),
        .reset      (reset),
        .arrive_raw (exit_arrive_raw),
        .pass_raw   (exit_pass_raw),
        .allow      (1'b1),
        .gate_open  (exit_gate_open),
        .done       (exit_done),
        .arrive_db  (exit_arrive_db),
        .state      (exit_state)
    );

    // The exit lane never refuses, so its status outputs have no consumer.
    assign unused_exit = ^{exit_state, exit_arrive_db};

    // FULL lamp: a waiting car is being refused at the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_denied <= 1'b0;
        end else begin
            entry_denied <= (entry_state == LANE_IDLE) && entry_arrive_db && parking_full;
        end
    end

    // Pulse registers; a simultaneous leave is deferred one cycle so the
    // two pulses are never high together.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_enter     <= 1'b0;
            car_leave     <= 1'b0;
            leave_pending <= 1'b0;
        end else begin
            car_enter     <= entry_done;
            car_leave     <= leave_pending | (exit_done & ~entry_done);
            leave_pending <= exit_done & entry_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_controller
//  Description : Directed self-checking bench for parking_gate_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic entry_arrive_raw = 1'b0;
    logic entry_pass_raw = 1'b0;
    logic exit_arrive_raw = 1'b0;
    logic exit_pass_raw = 1'b0;
    logic parking_full = 1'b0;
    logic car_enter;
    logic car_leave;
    logic entry_gate_open;
    logic exit_gate_open;
    logic entry_denied;

    int n_vec = 0;
    int n_err = 0;

    // Cycle counter and monitors, updated #1 after every rising edge.
    int cyc = 0;
    int n_enter = 0;
    int n_leave = 0;
    int n_both = 0;
    int n_gate = 0;
    int last_enter = -1;
    int last_leave = -1;

    parking_gate_controller dut (
        .clk              (clk),
        .reset            (reset),
        .entry_arrive_raw (entry_arrive_raw),
        .entry_pass_raw   (entry_pass_raw),
        .exit_arrive_raw  (exit_arrive_raw),
        .exit_pass_raw    (exit_pass_raw),
        .parking_full     (parking_full),
        .car_enter        (car_enter),
        .car_leave        (car_leave),
        .entry_gate_open  (entry_gate_open),
        .exit_gate_open   (exit_gate_open),
        .entry_denied     (entry_denied)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (car_enter) begin n_enter++; last_enter = cyc; end
        if (car_leave) begin n_leave++; last_leave = cyc; end
        if (car_enter && car_leave) n_both++;
        if (entry_gate_open || exit_gate_open) n_gate++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_mon();
        cyc = 0; n_enter = 0; n_leave = 0; n_both = 0; n_gate = 0;
        last_enter = -1; last_leave = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_vec++; if (car_enter !== 1'b0) begin n_err++; $display("FAIL rst_car_enter: got %b want 0", car_enter); end
        n_vec++; if (car_leave !== 1'b0) begin n_err++; $display("FAIL rst_car_leave: got %b want 0", car_leave); end
        n_vec++; if (entry_gate_open !== 1'b0) begin n_err++; $display("FAIL rst_entry_gate: got %b want 0", entry_gate_open); end
        n_vec++; if (exit_gate_open !== 1'b0) begin n_err++; $display("FAIL rst_exit_gate: got %b want 0", exit_gate_open); end
        n_vec++; if (entry_denied !== 1'b0) begin n_err++; $display("FAIL rst_denied: got %b want 0", entry_denied); end
        reset = 1'b0;
        idle(5);
        n_vec++; if (entry_gate_open !== 1'b0 || exit_gate_open !== 1'b0) begin
            n_err++; $display("FAIL post_rst_gates: got %b%b want 00", entry_gate_open, exit_gate_open);
        end
    endtask

    task automatic test_normal_entry();
        idle(5); clear_mon();
        entry_arrive_raw = 1'b1;
        run_to(4);
        n_vec++; if (entry_gate_open !== 1'b0) begin n_err++; $display("FAIL entry_gate_c4: got %b want 0", entry_gate_open); end
        run_to(5);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL entry_gate_c5: got %b want 1", entry_gate_open); end
        run_to(13);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL entry_gate_c13: got %b want 1", entry_gate_open); end
        entry_arrive_raw = 1'b0;
        entry_pass_raw = 1'b1;
        run_to(23);
        entry_pass_raw = 1'b0;
        run_to(27);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL entry_gate_c27: got %b want 1", entry_gate_open); end
        run_to(28);
        n_vec++; if (entry_gate_open !== 1'b0) begin n_err++; $display("FAIL entry_gate_c28: got %b want 0", entry_gate_open); end
        run_to(45);
        n_vec++; if (n_enter !== 1) begin n_err++; $display("FAIL entry_pulse_count: got %0d want 1", n_enter); end
        n_vec++; if (last_enter !== 29) begin n_err++; $display("FAIL entry_pulse_cycle: got %0d want 29", last_enter); end
        n_vec++; if (n_leave !== 0) begin n_err++; $display("FAIL entry_no_leave: got %0d want 0", n_leave); end
        n_vec++; if (n_gate !== 23) begin n_err++; $display("FAIL entry_gate_cycles: got %0d want 23", n_gate); end
    endtask

    task automatic test_full_lot();
        idle(5); clear_mon();
        parking_full = 1'b1;
        entry_arrive_raw = 1'b1;
        run_to(4);
        n_vec++; if (entry_denied !== 1'b0) begin n_err++; $display("FAIL full_denied_c4: got %b want 0", entry_denied); end
        run_to(5);
        n_vec++; if (entry_denied !== 1'b1) begin n_err++; $display("FAIL full_denied_c5: got %b want 1", entry_denied); end
        run_to(15);
        n_vec++; if (n_gate !== 0) begin n_err++; $display("FAIL full_gate_held: got %0d open cycles want 0", n_gate); end
        n_vec++; if (entry_denied !== 1'b1) begin n_err++; $display("FAIL full_denied_c15: got %b want 1", entry_denied); end
        parking_full = 1'b0;
        run_to(16);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL unfull_gate_c16: got %b want 1", entry_gate_open); end
        n_vec++; if (entry_denied !== 1'b0) begin n_err++; $display("FAIL unfull_denied_c16: got %b want 0", entry_denied); end
    endtask

    // Continues from test_full_lot: gate opened at cycle 16, car never passes.
    task automatic test_timeout();
        entry_arrive_raw = 1'b0;
        run_to(87);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL tmo_gate_c87: got %b want 1", entry_gate_open); end
        run_to(88);
        n_vec++; if (entry_gate_open !== 1'b0) begin n_err++; $display("FAIL tmo_gate_c88: got %b want 0", entry_gate_open); end
        run_to(110);
        n_vec++; if (n_enter !== 0) begin n_err++; $display("FAIL tmo_no_enter: got %0d want 0", n_enter); end
    endtask

    task automatic test_glitch();
        idle(5); clear_mon();
        for (int len = 1; len <= 3; len++) begin
            entry_arrive_raw = 1'b1;
            exit_arrive_raw = 1'b1;
            idle(len);
            entry_arrive_raw = 1'b0;
            exit_arrive_raw = 1'b0;
            idle(5);
        end
        // Pass loops occupied while idle: ignored.
        entry_pass_raw = 1'b1;
        exit_pass_raw = 1'b1;
        idle(10);
        entry_pass_raw = 1'b0;
        exit_pass_raw = 1'b0;
        idle(15);
        n_vec++; if (n_gate !== 0) begin n_err++; $display("FAIL glitch_gate: got %0d open cycles want 0", n_gate); end
        n_vec++; if (n_enter !== 0 || n_leave !== 0) begin
            n_err++; $display("FAIL glitch_pulses: got enter=%0d leave=%0d want 0/0", n_enter, n_leave);
        end
    endtask

    task automatic test_back_to_back();
        idle(5); clear_mon();
        entry_arrive_raw = 1'b1;
        exit_arrive_raw = 1'b1;
        run_to(5);
        n_vec++; if (exit_gate_open !== 1'b1) begin n_err++; $display("FAIL col_exit_gate_c5: got %b want 1", exit_gate_open); end
        run_to(8);
        parking_full = 1'b1;   // must not abort an entry already started
        run_to(13);
        entry_arrive_raw = 1'b0;
        exit_arrive_raw = 1'b0;
        entry_pass_raw = 1'b1;
        exit_pass_raw = 1'b1;
        run_to(20);
        n_vec++; if (entry_denied !== 1'b0) begin n_err++; $display("FAIL col_denied_c20: got %b want 0", entry_denied); end
        run_to(23);
        entry_pass_raw = 1'b0;
        exit_pass_raw = 1'b0;
        run_to(45);
        parking_full = 1'b0;
        n_vec++; if (n_enter !== 1) begin n_err++; $display("FAIL col_enter_count: got %0d want 1", n_enter); end
        n_vec++; if (last_enter !== 29) begin n_err++; $display("FAIL col_enter_cycle: got %0d want 29", last_enter); end
        n_vec++; if (n_leave !== 1) begin n_err++; $display("FAIL col_leave_count: got %0d want 1", n_leave); end
        n_vec++; if (last_leave !== 30) begin n_err++; $display("FAIL col_leave_cycle: got %0d want 30", last_leave); end
        n_vec++; if (n_both !== 0) begin n_err++; $display("FAIL col_overlap: got %0d cycles want 0", n_both); end
    endtask

    task automatic test_reset_mid_passing();
        idle(5); clear_mon();
        entry_arrive_raw = 1'b1;
        exit_arrive_raw = 1'b1;
        run_to(13);
        entry_arrive_raw = 1'b0;
        exit_arrive_raw = 1'b0;
        entry_pass_raw = 1'b1;
        exit_pass_raw = 1'b1;
        run_to(20);
        n_vec++; if (entry_gate_open !== 1'b1) begin n_err++; $display("FAIL rmid_gate_c20: got %b want 1", entry_gate_open); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (entry_gate_open !== 1'b0 || exit_gate_open !== 1'b0) begin
            n_err++; $display("FAIL rmid_gates_c21: got %b%b want 00", entry_gate_open, exit_gate_open);
        end
        entry_pass_raw = 1'b0;
        exit_pass_raw = 1'b0;
        clear_mon();
        idle(40);
        n_vec++; if (n_gate !== 0) begin n_err++; $display("FAIL rmid_gate_after: got %0d open cycles want 0", n_gate); end
        n_vec++; if (n_enter !== 0 || n_leave !== 0) begin
            n_err++; $display("FAIL rmid_pulses: got enter=%0d leave=%0d want 0/0", n_enter, n_leave);
        end
    endtask

    initial begin
        test_reset();
        test_normal_entry();
        test_full_lot();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_reset_mid_passing();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
